fifo_rd_stream_adapter: RTL and testbench

// Read-side consumer of the synchronous FIFO. Drains the FIFO through its r_en/data_out/empty

---
 rtl/fifo_rd_stream_adapter_if.sv | 24 ++
 rtl/fifo_rd_stream_adapter.sv | 108 ++++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_adapter_if.sv
// Signal bundle between the adapter, the FIFO read port and the downstream stream consumer.
// slave = the adapter itself; master = the environment around it (FIFO + consumer).
interface fifo_rd_stream_adapter_if #(
  parameter int WIDTH = 8
);
  // Stream handshake: a word transfers on a rising edge where out_valid && out_ready;
  // once out_valid is high it stays high with out_data stable until that transfer.
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_r_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  fifo_empty, fifo_data_out, out_ready,
    output fifo_r_en, out_valid, out_data
  );

  modport master (
    output fifo_empty, fifo_data_out, out_ready,
    input  fifo_r_en, out_valid, out_data
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a synchronous FIFO (1-cycle registered read) into a valid/ready stream through a
// small skid buffer; reads are issued from registered state only, never from out_ready.
module fifo_rd_stream_adapter #(
  parameter int WIDTH      = 8,
  parameter int SKID_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  fifo_rd_stream_adapter_if.slave           bus,
  input  logic                              flush,
  output logic [CNT_W-1:0]                  word_cnt,
  output logic                              idle,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   dbg_occ,
  output logic                              dbg_in_flight
);
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SKID_DEPTH - 1);
  localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(SKID_DEPTH);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_flight_q, in_flight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             issue;
  logic             capture;
  logic             pop;
  logic [OCC_W:0]   pending;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    cnt_d       = cnt_q;

    // Buffered plus in-flight words bound the issue, so the buffer can never overflow.
    pending     = {1'b0, occ_q} + (OCC_W + 1)'(in_flight_q);
    issue       = !rst && !flush && !bus.fifo_empty && (pending < DEPTH_EXT);
    capture     = in_flight_q && !flush;
    pop         = (occ_q != '0) && bus.out_ready;
    in_flight_d = issue;

    if (capture) begin
      mem_d[wr_ptr_q] = bus.fifo_data_out;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d    = cnt_q + CNT_W'(1);
    end
    if (capture && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!capture && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end

    // A flush still counts the word handed over in the same cycle.
    if (flush) begin
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      in_flight_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      in_flight_q <= in_flight_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_q <= OCC_W'(SKID_DEPTH));
    end
  end

  assign bus.fifo_r_en  = issue;
  assign bus.out_valid  = (occ_q != '0);
  assign bus.out_data   = mem_q[rd_ptr_q];
  assign word_cnt       = cnt_q;
  assign idle           = (occ_q == '0) && !in_flight_q && bus.fifo_empty;
  assign dbg_occ        = occ_q;
  assign dbg_in_flight  = in_flight_q;
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: two instances (depth 3 / 16-bit count, depth 4 / 4-bit count)
// each fed by a behavioural 1-cycle-latency FIFO, with a queue scoreboard on each stream.
module tb_fifo_rd_stream_adapter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, flush_a, flush_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic idle_a, idle_b, inf_a, inf_b;
  logic [1:0] occ_a;
  logic [2:0] occ_b;

  fifo_rd_stream_adapter_if #(.WIDTH(8)) bus_a ();
  fifo_rd_stream_adapter_if #(.WIDTH(8)) bus_b ();

  fifo_rd_stream_adapter #(.WIDTH(8), .SKID_DEPTH(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .flush(flush_a), .word_cnt(cnt_a),
    .idle(idle_a), .dbg_occ(occ_a), .dbg_in_flight(inf_a)
  );

  fifo_rd_stream_adapter #(.WIDTH(8), .SKID_DEPTH(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .flush(flush_b), .word_cnt(cnt_b),
    .idle(idle_b), .dbg_occ(occ_b), .dbg_in_flight(inf_b)
  );

  // Behavioural FIFOs: stimulus writes mem/wp, the read process owns rp and data_out.
  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;

  assign bus_a.fifo_empty = (rp_a == wp_a);
  assign bus_b.fifo_empty = (rp_b == wp_b);

  always @(posedge clk) begin
    if (bus_a.fifo_r_en) begin
      bus_a.fifo_data_out <= mem_a[rp_a];
      rp_a <= rp_a + 1;
    end
    if (bus_b.fifo_r_en) begin
      bus_b.fifo_data_out <= mem_b[rp_b];
      rp_b <= rp_b + 1;
    end
  end

  // Scoreboard
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int total = 0;
  int bad = 0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (bus_a.fifo_empty) begin
      total++;
      if (bus_a.fifo_r_en !== 1'b0) begin
        bad++;
        $display("FAIL underflow_a: fifo_r_en=%b while empty, required 0", bus_a.fifo_r_en);
      end
    end
    if (bus_b.fifo_empty) begin
      total++;
      if (bus_b.fifo_r_en !== 1'b0) begin
        bad++;
        $display("FAIL underflow_b: fifo_r_en=%b while empty, required 0", bus_b.fifo_r_en);
      end
    end
    if (bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL stream_a: unexpected word %0h, required none", bus_a.out_data);
      end else begin
        e = exp_a.pop_front();
        if (bus_a.out_data !== e) begin
          bad++;
          $display("FAIL stream_a: got %0h required %0h", bus_a.out_data, e);
        end
      end
    end
    if (bus_b.out_valid === 1'b1 && bus_b.out_ready === 1'b1) begin
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL stream_b: unexpected word %0h, required none", bus_b.out_data);
      end else begin
        e = exp_b.pop_front();
        if (bus_b.out_data !== e) begin
          bad++;
          $display("FAIL stream_b: got %0h required %0h", bus_b.out_data, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_a(input logic [7:0] v);
    mem_a[wp_a] = v;
    wp_a++;
    exp_a.push_back(v);
  endtask

  task automatic push_b(input logic [7:0] v);
    mem_b[wp_b] = v;
    wp_b++;
    exp_b.push_back(v);
  endtask

  task automatic drain(input bit sel, input string name);
    int n;
    n = 0;
    while (n < 500 && !(sel ? (exp_b.size() == 0 && idle_b) : (exp_a.size() == 0 && idle_a))) begin
      tick();
      n++;
    end
    check(name, (n < 500) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_en, n_val, last_en, pushed, cyc;
    rst_a = 1'b1; rst_b = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push_a(8'(i));

    // Reset with the FIFO non-empty
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ren", {31'd0, bus_a.fifo_r_en}, 32'd0);
      check("rst_valid", {31'd0, bus_a.out_valid}, 32'd0);
      check("rst_cnt", {16'd0, cnt_a}, 32'd0);
      check("rst_idle", {31'd0, idle_a}, 32'd0);
      check("rst_data", {24'd0, bus_a.out_data}, 32'd0);
    end
    check("rst_b_cnt", {28'd0, cnt_b}, 32'd0);

    // Streaming 0x01..0x10
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    n_en = 0; n_val = 0; last_en = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus_a.fifo_r_en) begin n_en++; last_en = i; end
      if (bus_a.out_valid) n_val++;
      if (i == 1) check("first_valid_low", {31'd0, bus_a.out_valid}, 32'd0);
      if (i == 2) begin
        check("first_valid_high", {31'd0, bus_a.out_valid}, 32'd1);
        check("first_data", {24'd0, bus_a.out_data}, 32'h01);
      end
      tick();
    end
    check("stream_ren_count", n_en, 16);
    check("stream_ren_last", last_en, 15);
    check("stream_valid_cycles", n_val, 16);
    check("stream_cnt", {16'd0, cnt_a}, 32'd16);
    check("stream_idle", {31'd0, idle_a}, 32'd1);

    // Backpressure: 8 words, downstream stalled
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_a(8'hA0 + 8'(i));
    #1;
    n_en = 0;
    if (bus_a.fifo_r_en) n_en++;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (bus_a.fifo_r_en) n_en++;
      if (i == 3) check("bp_hold_early", {24'd0, bus_a.out_data}, 32'hA0);
    end
    check("bp_reads", n_en, 3);
    check("bp_occ", {30'd0, occ_a}, 32'd3);
    check("bp_valid", {31'd0, bus_a.out_valid}, 32'd1);
    check("bp_hold_late", {24'd0, bus_a.out_data}, 32'hA0);
    bus_a.out_ready = 1'b1;
    drain(1'b0, "bp_drain");
    check("bp_cnt", {16'd0, cnt_a}, 32'd24);

    // Toggling ready with 200 random words trickling in
    pushed = 0; cyc = 0;
    while ((pushed < 200 || exp_a.size() != 0) && cyc < 3000) begin
      bus_a.out_ready = cyc[0];
      if (pushed < 200 && $urandom_range(0, 3) != 0) begin
        push_a(8'($urandom_range(0, 255)));
        pushed++;
      end
      tick();
      cyc++;
    end
    check("toggle_done", exp_a.size(), 0);
    bus_a.out_ready = 1'b1;
    drain(1'b0, "toggle_drain");
    check("toggle_cnt", {16'd0, cnt_a}, 32'd224);

    // Flush on depth-4 instance: 3 buffered + 1 in flight
    for (int i = 0; i < 8; i++) push_b(8'hB0 + 8'(i));
    for (int i = 0; i < 4; i++) tick();
    check("flush_pre_occ", {29'd0, occ_b}, 32'd3);
    check("flush_pre_inf", {31'd0, inf_b}, 32'd1);
    for (int i = 0; i < 4; i++) void'(exp_b.pop_front());
    flush_b = 1'b1;
    tick();
    flush_b = 1'b0;
    check("flush_valid_low", {31'd0, bus_b.out_valid}, 32'd0);
    check("flush_cnt", {28'd0, cnt_b}, 32'd0);
    tick();
    tick();
    check("flush_next_valid", {31'd0, bus_b.out_valid}, 32'd1);
    check("flush_next_data", {24'd0, bus_b.out_data}, 32'hB4);
    bus_b.out_ready = 1'b1;
    drain(1'b1, "flush_drain");
    check("flush_cnt_after", {28'd0, cnt_b}, 32'd4);

    // Counter wrap with a 4-bit count
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("wrap_rst_cnt", {28'd0, cnt_b}, 32'd0);
    for (int i = 0; i < 18; i++) push_b(8'hC0 + 8'(i));
    drain(1'b1, "wrap_drain");
    check("wrap_cnt", {28'd0, cnt_b}, 32'd2);

    // Reset mid-stream: D3 is buffered/in flight and lost, D4..D9 remain in the FIFO
    for (int i = 0; i < 10; i++) push_b(8'hD0 + 8'(i));
    for (int i = 0; i < 4; i++) tick();
    rst_b = 1'b1;
    tick();
    check("midrst_cnt", {28'd0, cnt_b}, 32'd0);
    check("midrst_valid", {31'd0, bus_b.out_valid}, 32'd0);
    exp_b.delete();
    for (int i = 4; i < 10; i++) exp_b.push_back(8'hD0 + 8'(i));
    rst_b = 1'b0;
    drain(1'b1, "midrst_drain");
    check("midrst_cnt_after", {28'd0, cnt_b}, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
